// File: rtl/uart_rx_fsm_if.sv
// Received-byte delivery bus from the UART RX core to the RX FIFO writer.
// Data and both error flags are qualified by the single-cycle valid strobe.
interface uart_rx_fsm_if;
    logic [7:0] Data_o;
    logic       p_DataValid_o;
    logic       p_ParityErr_o;
    logic       p_FrameErr_o;

    modport master (
        output Data_o,
        output p_DataValid_o,
        output p_ParityErr_o,
        output p_FrameErr_o
    );

    modport slave (
        input Data_o,
        input p_DataValid_o,
        input p_ParityErr_o,
        input p_FrameErr_o
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART RX state machine: oversampled start qualification, LSB-first shift, parity/stop check.
// Strobe 1 clk after the mid-stop-bit tick; no backpressure, the FIFO writer must accept every strobe.
module uart_rx_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_BaudSig16_i,
    input  logic                Rx_i,
    input  logic                ParityEnable_i,
    input  logic                ParityOdd_i,
    uart_rx_fsm_if.master       rx_if,
    output logic [4:0]          State_o,
    output logic [3:0]          BitCounter_o
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [4:0] {
        IDLE      = 5'b0_0001,
        STARTBIT  = 5'b0_0010,
        DATABITS  = 5'b0_0100,
        PARITYBIT = 5'b0_1000,
        STOPBIT   = 5'b1_0000
    } state_e;

    logic                 rx_meta_q, rx_s_q;
    logic [4:0]           st_a_q, st_b_q, st_c_q, st_v, st_d;
    logic [3:0]           bc_a_q, bc_b_q, bc_c_q, bc_v, bc_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic                 perr_q, perr_d;
    logic [7:0]           data_q, data_d;
    logic                 vld_q, vld_d, pflag_q, pflag_d, fflag_q, fflag_d;
    logic                 sample_pt;

    // Bitwise 2-of-3 vote; every copy is rewritten from the voted value each clk.
    assign st_v = (st_a_q & st_b_q) | (st_a_q & st_c_q) | (st_b_q & st_c_q);
    assign bc_v = (bc_a_q & bc_b_q) | (bc_a_q & bc_c_q) | (bc_b_q & bc_c_q);

    assign sample_pt = p_BaudSig16_i &&
                       (samp_q == ((st_v == STARTBIT) ? SAMP_MID : SAMP_END));

    always_comb begin
        st_d      = st_v;
        bc_d      = bc_v;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        perr_d    = perr_q;
        data_d    = data_q;
        vld_d     = 1'b0;
        pflag_d   = 1'b0;
        fflag_d   = 1'b0;

        case (st_v)
            IDLE: begin
                if (p_BaudSig16_i && !rx_s_q) begin
                    st_d      = STARTBIT;
                    par_en_d  = ParityEnable_i;
                    par_odd_d = ParityOdd_i;
                end
            end
            STARTBIT: begin
                if (sample_pt) begin
                    st_d = rx_s_q ? IDLE : DATABITS;
                end
            end
            DATABITS: begin
                if (sample_pt) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bc_v == LAST_BIT) begin
                        bc_d = '0;
                        st_d = par_en_q ? PARITYBIT : STOPBIT;
                    end else begin
                        bc_d = bc_v + 4'd1;
                    end
                end
            end
            PARITYBIT: begin
                if (sample_pt) begin
                    perr_d = (^shift_q) ^ rx_s_q ^ par_odd_q;
                    st_d   = STOPBIT;
                end
            end
            STOPBIT: begin
                if (sample_pt) begin
                    data_d                = '0;
                    data_d[DATA_BITS-1:0] = shift_q;
                    vld_d                 = 1'b1;
                    fflag_d               = ~rx_s_q;
                    pflag_d               = par_en_q & perr_q;
                    st_d                  = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
                bc_d = '0;
            end
        endcase

        if (st_d != st_v) begin
            samp_d = '0;
        end else if (p_BaudSig16_i) begin
            samp_d = samp_q + 1'b1;
        end else begin
            samp_d = samp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            st_a_q    <= IDLE;
            st_b_q    <= IDLE;
            st_c_q    <= IDLE;
            bc_a_q    <= '0;
            bc_b_q    <= '0;
            bc_c_q    <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            pflag_q   <= 1'b0;
            fflag_q   <= 1'b0;
        end else begin
            rx_meta_q <= Rx_i;
            rx_s_q    <= rx_meta_q;
            st_a_q    <= st_d;
            st_b_q    <= st_d;
            st_c_q    <= st_d;
            bc_a_q    <= bc_d;
            bc_b_q    <= bc_d;
            bc_c_q    <= bc_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            pflag_q   <= pflag_d;
            fflag_q   <= fflag_d;
        end
    end

    assign rx_if.Data_o        = data_q;
    assign rx_if.p_DataValid_o = vld_q;
    assign rx_if.p_ParityErr_o = pflag_q;
    assign rx_if.p_FrameErr_o  = fflag_q;
    assign State_o             = st_v;
    assign BitCounter_o        = bc_v;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: 8-bit and 5-bit receivers driven with directed serial frames.
module tb_uart_rx_fsm;
    localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clks

    logic clk, rst, tick, rx_a, rx_b, pe, po;
    logic [4:0] st_a, st_b;
    logic [3:0] bc_a, bc_b;
    int checks = 0;
    int errors = 0;
    int lat;
    int guard;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    uart_rx_fsm_if if_a();
    uart_rx_fsm_if if_b();

    uart_rx_fsm #(.DATA_BITS(8), .OVERSAMPLE(16)) dut_a (
        .clk(clk), .rst(rst), .p_BaudSig16_i(tick), .Rx_i(rx_a),
        .ParityEnable_i(pe), .ParityOdd_i(po), .rx_if(if_a),
        .State_o(st_a), .BitCounter_o(bc_a)
    );

    uart_rx_fsm #(.DATA_BITS(5), .OVERSAMPLE(16)) dut_b (
        .clk(clk), .rst(rst), .p_BaudSig16_i(tick), .Rx_i(rx_b),
        .ParityEnable_i(pe), .ParityOdd_i(po), .rx_if(if_b),
        .State_o(st_b), .BitCounter_o(bc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                tick = (i == 3);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        return e;
    endfunction

    task automatic drive(input bit to_b, input logic v);
        if (to_b) rx_b = v;
        else      rx_a = v;
    endtask

    task automatic bit_time(input int n);
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input bit to_b, input logic [7:0] d, input int nb,
                              input logic par_on, input logic par_bit, input logic stop_bit);
        drive(to_b, 1'b0);
        bit_time(1);
        for (int i = 0; i < nb; i++) begin
            drive(to_b, d[i]);
            bit_time(1);
        end
        if (par_on) begin
            drive(to_b, par_bit);
            bit_time(1);
        end
        drive(to_b, stop_bit);
        bit_time(1);
    endtask

    // Scoreboard monitors: pop one expectation per strobe, flags must be 0 otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (if_a.p_DataValid_o) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_strobe: got strobe data %0h, expected none", if_a.Data_o);
                end else begin
                    e_a = q_a.pop_front();
                    check("a_data", 32'(if_a.Data_o), 32'(e_a.data));
                    check("a_parity_err", 32'(if_a.p_ParityErr_o), 32'(e_a.perr));
                    check("a_frame_err", 32'(if_a.p_FrameErr_o), 32'(e_a.ferr));
                end
            end else begin
                check("a_flags_without_valid", 32'({if_a.p_ParityErr_o, if_a.p_FrameErr_o}), 32'd0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (if_b.p_DataValid_o) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_strobe: got strobe data %0h, expected none", if_b.Data_o);
                end else begin
                    e_b = q_b.pop_front();
                    check("b_data", 32'(if_b.Data_o), 32'(e_b.data));
                    check("b_parity_err", 32'(if_b.p_ParityErr_o), 32'(e_b.perr));
                    check("b_frame_err", 32'(if_b.p_FrameErr_o), 32'(e_b.ferr));
                end
            end else begin
                check("b_flags_without_valid", 32'({if_b.p_ParityErr_o, if_b.p_FrameErr_o}), 32'd0);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        pe   = 1'b0;
        po   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state_a", 32'(st_a), 32'h01);
        check("reset_state_b", 32'(st_b), 32'h01);
        check("reset_bitcnt_a", 32'(bc_a), 32'h0);
        check("reset_data_a", 32'(if_a.Data_o), 32'h0);
        check("reset_valid_a", 32'(if_a.p_DataValid_o), 32'h0);
        rst = 1'b0;
        repeat (100) @(negedge clk);

        // 8N1 0xA5 with strobe latency measured from the falling start edge
        q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
        fork
            send_frame(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
            begin
                lat = 0;
                while (!if_a.p_DataValid_o && lat < 1000) begin
                    @(negedge clk);
                    lat++;
                end
                checks++;
                if (lat < 605 || lat > 620) begin
                    errors++;
                    $display("FAIL a_strobe_latency: got %0d clks, expected 605..620", lat);
                end
            end
        join
        bit_time(2);

        // 0x37 has five ones: even-parity bit 1 is correct, odd-parity bit 1 is wrong
        pe = 1'b1;
        po = 1'b0;
        q_a.push_back(mk(8'h37, 1'b0, 1'b0));
        send_frame(1'b0, 8'h37, 8, 1'b1, 1'b1, 1'b1);
        bit_time(2);
        po = 1'b1;
        q_a.push_back(mk(8'h37, 1'b1, 1'b0));
        send_frame(1'b0, 8'h37, 8, 1'b1, 1'b1, 1'b1);
        bit_time(2);
        pe = 1'b0;
        po = 1'b0;

        // 3-tick low glitch on idle line
        rx_a = 1'b0;
        repeat (12) @(negedge clk);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        check("a_glitch_in_startbit", 32'(st_a), 32'h02);
        repeat (40) @(negedge clk);
        check("a_glitch_back_to_idle", 32'(st_a), 32'h01);
        bit_time(1);

        // Low stop bit, then line held low: one break frame of 0x00 whose stop bit sees
        // the line released high, so it completes without a frame error.
        q_a.push_back(mk(8'h55, 1'b0, 1'b1));
        q_a.push_back(mk(8'h00, 1'b0, 1'b0));
        send_frame(1'b0, 8'h55, 8, 1'b0, 1'b0, 1'b0);
        bit_time(9);
        rx_a = 1'b1;
        bit_time(3);
        q_a.push_back(mk(8'h0F, 1'b0, 1'b0));
        send_frame(1'b0, 8'h0F, 8, 1'b0, 1'b0, 1'b1);
        bit_time(2);

        // 5-bit receiver, back-to-back frames with no idle gap
        q_b.push_back(mk(8'h13, 1'b0, 1'b0));
        q_b.push_back(mk(8'h0A, 1'b0, 1'b0));
        q_b.push_back(mk(8'h1F, 1'b0, 1'b0));
        send_frame(1'b1, 8'h13, 5, 1'b0, 1'b0, 1'b1);
        send_frame(1'b1, 8'h0A, 5, 1'b0, 1'b0, 1'b1);
        send_frame(1'b1, 8'h1F, 5, 1'b0, 1'b0, 1'b1);
        bit_time(2);

        // Reset in the middle of data bit 4 of 0xC3 aborts the frame
        rx_a = 1'b0;
        bit_time(1);
        for (int i = 0; i < 4; i++) begin
            rx_a = ((8'hC3 >> i) & 8'h01) != 8'h00;
            bit_time(1);
        end
        rx_a = 1'b0;
        repeat (32) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midframe_reset_state_a", 32'(st_a), 32'h01);
        check("midframe_reset_bitcnt_a", 32'(bc_a), 32'h0);
        check("midframe_reset_data_a", 32'(if_a.Data_o), 32'h0);
        check("midframe_reset_data_b", 32'(if_b.Data_o), 32'h0);
        rst  = 1'b0;
        rx_a = 1'b1;
        bit_time(3);

        // One corrupted state copy mid-frame must not disturb reception
        q_a.push_back(mk(8'hC3, 1'b0, 1'b0));
        fork
            send_frame(1'b0, 8'hC3, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (3 * BIT_CLKS + 10) @(negedge clk);
                force dut_a.st_b_q = 5'b11111;
                repeat (2) @(negedge clk);
                check("a_state_with_bad_copy", 32'(st_a), 32'h04);
                repeat (14) @(negedge clk);
                release dut_a.st_b_q;
            end
        join
        bit_time(2);

        // Two copies agreeing on an illegal code: voted state is illegal, then recovers to IDLE
        force dut_a.st_a_q = 5'b00110;
        force dut_a.st_b_q = 5'b00110;
        @(negedge clk);
        check("a_voted_illegal_visible", 32'(st_a), 32'h06);
        release dut_a.st_a_q;
        release dut_a.st_b_q;
        @(negedge clk);
        check("a_illegal_recovers_idle", 32'(st_a), 32'h01);
        bit_time(1);

        guard = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("a_missing_strobes", 32'(q_a.size()), 32'd0);
        check("b_missing_strobes", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
